fsk_demod_core: RTL and testbench

Parametrised FSK/FM demodulator back-end that replaces the fixed chain of phase unwrap, differentiator, FIR and offset conversion. It sits after the I/Q mixer and CORDIC arctangent. Per input sample it computes the wrapped phase difference (instantaneous frequency), smooths it with a power-of-two boxcar, and drives an offset-binary frequency word for the DAC path. In bit mode it also slices the frequency, recovers symbol timing and emits demodulated bits with a lock flag.

---
 rtl/fsk_demod_core.sv | 172 +++++++++++++++++
 tb/tb_fsk_demod_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_demod_core.sv
// fsk_demod_core: phase-difference FM demodulator with boxcar smoothing, offset-binary output and bit slicer
module fsk_demod_core #(
    parameter int PH_W     = 16,
    parameter int AVG_LOG2 = 3,
    parameter int OUT_W    = 10,
    parameter int SPS      = 32,
    parameter int DECAY_SH = 8,
    parameter int MIN_SPAN = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [PH_W-1:0]  phase_in,
    input  logic             mode,
    output logic [OUT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             lock
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int IW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int FW = AVG_LOG2 + 1;
    localparam int SW = PH_W + AVG_LOG2;
    localparam int TW = PH_W + 2;
    localparam int CW = $clog2(SPS);

    typedef enum logic {ACQ, LOCK} state_t;

    logic [PH_W-1:0]        prev_q, prev_d;
    logic                   primed_q, primed_d, dv_q, dv_d;
    logic signed [PH_W-1:0] d_q, d_d;
    logic signed [PH_W-1:0] win_q [N];
    logic signed [PH_W-1:0] win_d [N];
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic                   sv_q, sv_d;
    logic signed [PH_W-1:0] avg, avg_q, avg_d;
    logic [OUT_W-1:0]       fo_q, fo_d;
    logic                   fv_q, fv_d;
    logic signed [PH_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sp_q, sp_d, bo_q, bo_d, bv_q, bv_d;
    logic [3:0]             good_q, good_d;
    state_t                 state_q, state_d;
    logic signed [TW-1:0]   hx, lx, ax, span, dec, nhi, nlo, thr, nspan;
    logic                   s, sedge, emit, ok;

    assign freq_out   = fo_q;
    assign freq_valid = fv_q;
    assign bit_out    = bo_q;
    assign bit_valid  = bv_q;
    assign lock       = (state_q == LOCK);

    // Wrapped phase difference, then running boxcar sum over the last N diffs
    always_comb begin
        primed_d = primed_q | in_valid;
        prev_d   = in_valid ? phase_in : prev_q;
        dv_d     = in_valid & primed_q;
        d_d      = in_valid ? phase_in - prev_q : d_q;
        win_d    = win_q;
        if (dv_q) win_d[ptr_q] = d_q;
        ptr_d    = dv_q ? (ptr_q == IW'(N - 1) ? '0 : ptr_q + IW'(1)) : ptr_q;
        fill_d   = (dv_q && fill_q != FW'(N)) ? fill_q + FW'(1) : fill_q;
        sum_d    = dv_q ? sum_q + SW'(d_q) - SW'(win_q[ptr_q]) : sum_q;
        sv_d     = dv_q && (fill_q >= FW'(N - 1));
    end

    // Average and offset-binary conversion; the average is kept for the slicer
    always_comb begin
        avg   = PH_W'(sum_q >>> AVG_LOG2);
        fv_d  = sv_q;
        fo_d  = sv_q ? {~avg[PH_W-1], avg[PH_W-2 -: OUT_W-1]} : fo_q;
        avg_d = sv_q ? avg : avg_q;
    end

    // Slicer: envelope trackers, mid-level decision, symbol timing and lock FSM
    always_comb begin
        hx      = TW'(hi_q);
        lx      = TW'(lo_q);
        ax      = TW'(avg_q);
        span    = hx - lx;
        dec     = span >>> DECAY_SH;
        nhi     = ax > hx ? ax : hx - dec;
        nlo     = ax < lx ? ax : lx + dec;
        thr     = (nhi + nlo) >>> 1;
        s       = ax >= thr;
        nspan   = nhi - nlo;
        ok      = nspan >= TW'(MIN_SPAN);
        sedge   = s != sp_q;
        emit    = !sedge && cnt_q == CW'(SPS / 2);
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        bo_d    = bo_q;
        bv_d    = 1'b0;
        good_d  = good_q;
        state_d = state_q;
        if (!mode) begin
            hi_d    = '0;
            lo_d    = '0;
            cnt_d   = '0;
            sp_d    = 1'b0;
            good_d  = '0;
            state_d = ACQ;
        end else if (fv_q) begin
            hi_d  = PH_W'(nhi);
            lo_d  = PH_W'(nlo);
            sp_d  = s;
            cnt_d = sedge ? CW'(1) : (cnt_q == CW'(SPS - 1) ? '0 : cnt_q + CW'(1));
            bv_d  = emit;
            bo_d  = emit ? s : bo_q;
            if (state_q == LOCK) begin
                state_d = ok ? LOCK : ACQ;
                good_d  = '0;
            end else if (emit) begin
                good_d  = ok ? good_q + 4'd1 : '0;
                state_d = (ok && good_q == 4'd7) ? LOCK : ACQ;
                if (ok && good_q == 4'd7) good_d = '0;
            end
        end
    end

    // Pipeline and slicer state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            dv_q     <= 1'b0;
            d_q      <= '0;
            for (int i = 0; i < N; i++) win_q[i] <= '0;
            ptr_q    <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            sv_q     <= 1'b0;
            avg_q    <= '0;
            fo_q     <= '0;
            fv_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            sp_q     <= 1'b0;
            bo_q     <= 1'b0;
            bv_q     <= 1'b0;
            good_q   <= '0;
            state_q  <= ACQ;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            dv_q     <= dv_d;
            d_q      <= d_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            sv_q     <= sv_d;
            avg_q    <= avg_d;
            fo_q     <= fo_d;
            fv_q     <= fv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            sp_q     <= sp_d;
            bo_q     <= bo_d;
            bv_q     <= bv_d;
            good_q   <= good_d;
            state_q  <= state_d;
        end
    end
endmodule

// File: tb/tb_fsk_demod_core.sv
// tb_fsk_demod_core: randomized checks of fsk_demod_core against an arithmetic reference model
module tb_fsk_demod_core;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, mode = 1'b0;
    logic [15:0] phase_in = '0;
    logic [9:0]  freq_out;
    logic        freq_valid, bit_out, bit_valid, lock;
    int          checks = 0, failures = 0;

    // reference model state
    logic        m_primed;
    logic [15:0] m_prev;
    int          m_win[$];
    logic        m_p1_v, m_p2_v;
    int          m_p1_a, m_p2_a, m_cur;
    int          m_hi, m_lo, m_cnt, m_good;
    logic        m_sp, m_locked;
    logic        exp_fv, exp_bv, exp_bo, exp_lk;
    int          exp_fo;
    logic [7:0]  pat = 8'b10110010;

    always #5 clk = ~clk;

    fsk_demod_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .phase_in(phase_in), .mode(mode),
        .freq_out(freq_out), .freq_valid(freq_valid), .bit_out(bit_out),
        .bit_valid(bit_valid), .lock(lock)
    );

    task automatic model_clear_slicer();
        m_hi = 0; m_lo = 0; m_cnt = 0; m_sp = 0; m_locked = 0; m_good = 0;
    endtask

    // One rising edge of the reference: slicer, output stage, then window update
    task automatic model_edge();
        logic signed [15:0] dd;
        int s_sum, span, dec, nhi, nlo, thr, nspan, a;
        logic s, emit, ok;
        if (rst) begin
            m_primed = 0; m_prev = 0; m_win.delete();
            m_p1_v = 0; m_p2_v = 0; m_cur = 0;
            model_clear_slicer();
            exp_fv = 0; exp_fo = 0; exp_bv = 0; exp_bo = 0; exp_lk = 0;
            return;
        end
        exp_bv = 0;
        if (!mode) model_clear_slicer();
        else if (exp_fv) begin
            a = m_cur;
            span = m_hi - m_lo;
            dec = span >>> 8;
            nhi = (a > m_hi) ? a : m_hi - dec;
            nlo = (a < m_lo) ? a : m_lo + dec;
            thr = (nhi + nlo) >>> 1;
            s = (a >= thr);
            nspan = nhi - nlo;
            ok = (nspan >= 512);
            emit = 0;
            if (s != m_sp) m_cnt = 1;
            else begin
                emit = (m_cnt == 16);
                m_cnt = (m_cnt + 1) % 32;
            end
            m_sp = s; m_hi = nhi; m_lo = nlo;
            if (emit) begin exp_bv = 1; exp_bo = s; end
            if (m_locked) begin
                if (!ok) begin m_locked = 0; m_good = 0; end
            end else if (emit) begin
                m_good = ok ? m_good + 1 : 0;
                if (m_good == 8) begin m_locked = 1; m_good = 0; end
            end
        end
        exp_lk = m_locked;
        exp_fv = m_p2_v;
        if (m_p2_v) begin m_cur = m_p2_a; exp_fo = (m_p2_a + 32768) / 64; end
        m_p2_v = m_p1_v; m_p2_a = m_p1_a; m_p1_v = 0;
        if (in_valid) begin
            if (m_primed) begin
                dd = phase_in - m_prev;
                m_win.push_back(int'(dd));
                if (m_win.size() > 8) void'(m_win.pop_front());
                if (m_win.size() == 8) begin
                    s_sum = 0;
                    foreach (m_win[i]) s_sum += m_win[i];
                    m_p1_v = 1; m_p1_a = s_sum >>> 3;
                end
            end
            m_primed = 1; m_prev = phase_in;
        end
    endtask

    task automatic step(input logic v, input logic [15:0] ph);
        in_valid = v; phase_in = ph;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; step(1'b0, 16'h0); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; mode = 1;
        step(1'b1, 16'($urandom));
        step(1'b1, 16'($urandom));
        checks++; if (freq_out !== 10'd0) begin failures++; $display("FAIL reset_freq_out got=%0d exp=0", freq_out); end
        checks++; if (freq_valid !== 1'b0) begin failures++; $display("FAIL reset_freq_valid got=%b exp=0", freq_valid); end
        checks++; if (bit_out !== 1'b0) begin failures++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
        checks++; if (bit_valid !== 1'b0) begin failures++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", lock); end
        rst = 0; mode = 0;
    endtask

    task automatic test_const_step(input string name, input logic [15:0] start, input logic [15:0] inc, input int steady);
        logic [15:0] ph;
        int first;
        do_reset();
        mode = 0; ph = start; first = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, ph);
            ph = ph + inc;
            checks++;
            if (freq_valid !== exp_fv) begin failures++; $display("FAIL %s_valid cyc=%0d got=%b exp=%b", name, i, freq_valid, exp_fv); end
            if (exp_fv) begin
                checks++;
                if (freq_out !== 10'(exp_fo)) begin failures++; $display("FAIL %s_model cyc=%0d got=%0d exp=%0d", name, i, freq_out, exp_fo); end
                checks++;
                if (freq_out !== 10'(steady)) begin failures++; $display("FAIL %s_steady cyc=%0d got=%0d exp=%0d", name, i, freq_out, steady); end
            end
            if (freq_valid === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first != 10) begin failures++; $display("FAIL %s_first_valid got=%0d exp=10", name, first); end
    endtask

    task automatic test_bit_mode();
        logic [15:0] ph;
        logic bits[$];
        logic lock_seen, found, good;
        int n_last;
        do_reset();
        mode = 1; ph = 16'($urandom); lock_seen = 0; n_last = 0;
        for (int rep = 0; rep < 6; rep++)
            for (int b = 0; b < 8; b++)
                for (int k = 0; k < 32; k++) begin
                    ph = pat[7-b] ? ph + 16'd2048 : ph - 16'd2048;
                    step(1'b1, ph);
                    checks++; if (bit_valid !== exp_bv) begin failures++; $display("FAIL bit_valid r=%0d b=%0d k=%0d got=%b exp=%b", rep, b, k, bit_valid, exp_bv); end
                    if (exp_bv) begin checks++; if (bit_out !== exp_bo) begin failures++; $display("FAIL bit_out r=%0d b=%0d got=%b exp=%b", rep, b, bit_out, exp_bo); end end
                    checks++; if (lock !== exp_lk) begin failures++; $display("FAIL bit_lock r=%0d b=%0d k=%0d got=%b exp=%b", rep, b, k, lock, exp_lk); end
                    if (bit_valid === 1'b1) begin bits.push_back(bit_out); if (rep == 5) n_last++; end
                    if (lock === 1'b1) lock_seen = 1;
                end
        checks++; if (lock_seen !== 1'b1) begin failures++; $display("FAIL bit_lock_rise got=0 exp=1"); end
        checks++; if (n_last != 8) begin failures++; $display("FAIL bit_rate got=%0d exp=8", n_last); end
        found = 0;
        if (bits.size() >= 16)
            for (int r = 0; r < 8; r++) begin
                good = 1;
                for (int i = 0; i < 16; i++) if (bits[bits.size()-16+i] !== pat[7-((r+i)%8)]) good = 0;
                if (good) found = 1;
            end
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL bit_pattern got=nomatch exp=10110010 n=%0d", bits.size()); end
        for (int i = 0; i < 800; i++) begin
            step(1'b1, ph);
            checks++; if (lock !== exp_lk) begin failures++; $display("FAIL decay_lock cyc=%0d got=%b exp=%b", i, lock, exp_lk); end
            checks++; if (bit_valid !== exp_bv) begin failures++; $display("FAIL decay_bit_valid cyc=%0d got=%b exp=%b", i, bit_valid, exp_bv); end
        end
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL decay_lock_drop got=%b exp=0", lock); end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] ph;
        int first;
        do_reset();
        mode = 1; ph = 16'($urandom); first = -1;
        for (int i = 0; i < 20; i++) begin ph = ph + 16'(300 + $urandom_range(0, 50)); step(1'b1, ph); end
        rst = 1; ph = ph + 16'd300; step(1'b1, ph); rst = 0;
        checks++; if ({freq_out, freq_valid, bit_out, bit_valid, lock} !== 14'd0)
            begin failures++; $display("FAIL mid_reset_outputs got=%h exp=0", {freq_out, freq_valid, bit_out, bit_valid, lock}); end
        for (int i = 0; i < 16; i++) begin
            ph = ph + 16'd300;
            step(1'b1, ph);
            checks++; if (freq_valid !== exp_fv) begin failures++; $display("FAIL mid_valid cyc=%0d got=%b exp=%b", i, freq_valid, exp_fv); end
            if (exp_fv) begin checks++; if (freq_out !== 10'(exp_fo)) begin failures++; $display("FAIL mid_freq cyc=%0d got=%0d exp=%0d", i, freq_out, exp_fo); end end
            if (freq_valid === 1'b1 && first < 0) first = i;
        end
        checks++; if (first != 10) begin failures++; $display("FAIL mid_first_valid got=%0d exp=10", first); end
        mode = 0;
    endtask

    task automatic test_gapped();
        logic [15:0] phs[60];
        int ref_q[$];
        int idx, seq;
        logic v;
        phs[0] = 16'($urandom);
        for (int i = 1; i < 60; i++) phs[i] = phs[i-1] + 16'($urandom_range(0, 6000)) - 16'd3000;
        do_reset();
        mode = 0;
        for (int i = 0; i < 64; i++) begin
            step(i < 60, phs[i < 60 ? i : 59]);
            checks++; if (freq_valid !== exp_fv) begin failures++; $display("FAIL cont_valid cyc=%0d got=%b exp=%b", i, freq_valid, exp_fv); end
            if (exp_fv) begin
                ref_q.push_back(exp_fo);
                checks++; if (freq_out !== 10'(exp_fo)) begin failures++; $display("FAIL cont_freq cyc=%0d got=%0d exp=%0d", i, freq_out, exp_fo); end
            end
        end
        do_reset();
        mode = 1; idx = 0; seq = 0;
        for (int c = 0; c < 190; c++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            v = (c % 3 == 0) && (idx < 60);
            step(v, v ? phs[idx] : phase_in);
            if (v) idx++;
            checks++; if (freq_valid !== exp_fv) begin failures++; $display("FAIL gap_valid cyc=%0d got=%b exp=%b", c, freq_valid, exp_fv); end
            if (freq_valid === 1'b1) begin
                checks++;
                if (seq >= ref_q.size() || freq_out !== 10'(ref_q[seq >= ref_q.size() ? 0 : seq]))
                    begin failures++; $display("FAIL gap_seq n=%0d got=%0d exp=%0d", seq, freq_out, seq < ref_q.size() ? ref_q[seq] : -1); end
                seq++;
            end
            checks++; if (bit_valid !== exp_bv) begin failures++; $display("FAIL gap_bit_valid cyc=%0d got=%b exp=%b", c, bit_valid, exp_bv); end
            if (exp_bv) begin checks++; if (bit_out !== exp_bo) begin failures++; $display("FAIL gap_bit_out cyc=%0d got=%b exp=%b", c, bit_out, exp_bo); end end
            checks++; if (lock !== exp_lk) begin failures++; $display("FAIL gap_lock cyc=%0d got=%b exp=%b", c, lock, exp_lk); end
        end
        checks++; if (seq != ref_q.size()) begin failures++; $display("FAIL gap_count got=%0d exp=%0d", seq, ref_q.size()); end
        mode = 0;
    endtask

    initial begin
        test_reset();
        test_const_step("const", 16'($urandom), 16'd256, 516);
        test_const_step("wrap", 16'd32000, 16'd136, 514);
        test_const_step("neg", 16'($urandom), 16'hF800, 480);
        test_bit_mode();
        test_reset_mid();
        test_gapped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
